// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter and sequencing stage downstream of the ALU.
// Resolves conditional branches from the ALU compare bit, produces the
// fetch address, brackets each run with an IDLE/RUN/DONE state machine
// and counts retired instructions with saturation.
module pc_ctrl #(
    parameter int PW = 10,
    parameter int D  = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          halt,
    input  logic          br_en,
    input  logic          br_flag,
    input  logic [D-1:0]  lut_sel,
    input  logic          lut_we,
    input  logic [D-1:0]  lut_waddr,
    input  logic [PW-1:0] lut_wdata,
    output logic [PW-1:0] prog_ctr,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] instr_cnt
);

    localparam int unsigned DEPTH = 1 << D;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] lut [DEPTH];
    logic [PW-1:0] br_target;

    // Branch target is read combinationally from the stored array, so a
    // same-cycle write to the same index is only seen on the next cycle.
    assign br_target = lut[lut_sel];

    // Status outputs are direct decodes of the registered state.
    assign running = (state == RUN);
    assign done    = (state == DONE);

    // Sequencing FSM: state, program counter and retired-instruction count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prog_ctr  <= '0;
            instr_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        prog_ctr  <= '0;
                        instr_cnt <= '0;
                    end
                end
                RUN: begin
                    // Every RUN cycle retires one instruction, halt included.
                    if (instr_cnt != '1) begin
                        instr_cnt <= instr_cnt + 1'b1;
                    end
                    if (halt) begin
                        state <= DONE;
                    end else if (br_en && br_flag) begin
                        prog_ctr <= br_target;
                    end else begin
                        prog_ctr <= prog_ctr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Branch-target LUT: writable in any state, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

endmodule
